// File: rtl/sample_loader_if.sv
// Byte-stream input, storage write ports and status for sample_loader.
// master drives the stream and control; slave is the loader.
interface sample_loader_if #(
    parameter int DATA_WIDTH = 48
);
    logic                  start;
    logic                  abort;
    logic                  in_valid;
    logic [7:0]            in_byte;
    logic                  in_ready;
    logic [31:0]           input_storage_write_layer_index;
    logic [31:0]           input_storage_write_row_index;
    logic [DATA_WIDTH-1:0] input_storage_write_data;
    logic                  input_storage_is_write;
    logic [31:0]           label_storage_write_layer_index;
    logic [31:0]           label_storage_write_row_index;
    logic [DATA_WIDTH-1:0] label_storage_write_data;
    logic                  label_storage_is_write;
    logic                  busy;
    logic                  sample_done;
    logic                  checksum_error;

    modport master (
        output start, abort, in_valid, in_byte,
        input  in_ready,
        input  input_storage_write_layer_index, input_storage_write_row_index,
        input  input_storage_write_data, input_storage_is_write,
        input  label_storage_write_layer_index, label_storage_write_row_index,
        input  label_storage_write_data, label_storage_is_write,
        input  busy, sample_done, checksum_error
    );

    modport slave (
        input  start, abort, in_valid, in_byte,
        output in_ready,
        output input_storage_write_layer_index, input_storage_write_row_index,
        output input_storage_write_data, input_storage_is_write,
        output label_storage_write_layer_index, label_storage_write_row_index,
        output label_storage_write_data, label_storage_is_write,
        output busy, sample_done, checksum_error
    );
endinterface

// File: rtl/sample_loader.sv
// Assembles a byte stream into little-endian words for input/label storage; write strobe 1 cycle after a word's last byte, in_ready held for the whole sample.
// SAMPLE_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte that gates sample_done.
module sample_loader #(
    parameter int DATA_WIDTH     = 48,
    parameter int BYTES_PER_WORD = 6,
    parameter int INPUT_ROWS     = 4,
    parameter int LABEL_ROWS     = 2,
    parameter int NUM_SLOTS      = 2
) (
    input  logic           clk_clk,
    input  logic           reset_reset,
    sample_loader_if.slave bus
);
    localparam int BW = $clog2(BYTES_PER_WORD + 1);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_INPUT,
        S_LOAD_LABEL,
`ifdef SAMPLE_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [BW-1:0]         r_byte_cnt;
    logic [31:0]           r_row_cnt;
    logic [SW-1:0]         r_slot;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_in_wr;
    logic [31:0]           r_in_row;
    logic [31:0]           r_in_layer;
    logic [DATA_WIDTH-1:0] r_in_data;
    logic                  r_lb_wr;
    logic [31:0]           r_lb_row;
    logic [31:0]           r_lb_layer;
    logic [DATA_WIDTH-1:0] r_lb_data;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_loading;
    logic                  w_last_byte;
    logic                  w_last_in;
    logic                  w_last_lb;
    logic                  w_lbl_full;
    logic                  w_word_done;
    logic                  w_abort;
    logic                  w_done;
    logic                  w_cerr;
`ifdef SAMPLE_LOADER_CHECKSUM_EN
    logic [7:0]            r_sum;
    logic                  r_cerr;
`endif

    // Without a checksum, one drain cycle after the last label byte (row count
    // == LABEL_ROWS) lets the final label strobe precede sample_done.
    assign w_lbl_full  = (r_row_cnt == 32'(LABEL_ROWS));
    assign w_loading   = (r_state == S_LOAD_INPUT) || (r_state == S_LOAD_LABEL);
    assign w_in_ready  = (r_state == S_LOAD_INPUT)
                       || ((r_state == S_LOAD_LABEL) && !w_lbl_full)
`ifdef SAMPLE_LOADER_CHECKSUM_EN
                       || (r_state == S_CHECK)
`endif
                       ;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_last_byte = (r_byte_cnt == BW'(BYTES_PER_WORD - 1));
    assign w_last_in   = (r_row_cnt == 32'(INPUT_ROWS - 1));
    assign w_last_lb   = (r_row_cnt == 32'(LABEL_ROWS - 1));
    assign w_word_done = w_accept && w_loading && w_last_byte;
    assign w_abort     = bus.abort && (r_state != S_IDLE);

    always_comb begin
        w_word = r_shift;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (r_byte_cnt == BW'(k)) w_word[8*k +: 8] = bus.in_byte;
        end
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_cerr = 1'b0;
        case (r_state)
            S_IDLE:       if (bus.start) w_next = S_LOAD_INPUT;
            S_LOAD_INPUT: if (w_word_done && w_last_in) w_next = S_LOAD_LABEL;
`ifdef SAMPLE_LOADER_CHECKSUM_EN
            S_LOAD_LABEL: if (w_word_done && w_last_lb) w_next = S_CHECK;
            S_CHECK: begin
                if (w_accept) begin
                    if (bus.in_byte == r_sum) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_IDLE;
                        w_cerr = 1'b1;
                    end
                end
            end
`else
            S_LOAD_LABEL: if (w_lbl_full) w_next = S_DONE;
`endif
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
            w_done = 1'b0;
            w_cerr = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_byte_cnt <= '0;
            r_row_cnt  <= '0;
            r_slot     <= '0;
            r_shift    <= '0;
            r_in_wr    <= 1'b0;
            r_in_row   <= '0;
            r_in_layer <= '0;
            r_in_data  <= '0;
            r_lb_wr    <= 1'b0;
            r_lb_row   <= '0;
            r_lb_layer <= '0;
            r_lb_data  <= '0;
        end else begin
            r_in_wr <= 1'b0;
            r_lb_wr <= 1'b0;
            if (r_state == S_IDLE) begin
                if (bus.start) begin
                    r_byte_cnt <= '0;
                    r_row_cnt  <= '0;
                end
            end else if (w_abort) begin
                r_byte_cnt <= '0;
            end else if (w_accept && w_loading) begin
                if (w_last_byte) begin
                    r_byte_cnt <= '0;
                    if (r_state == S_LOAD_INPUT) begin
                        r_in_wr    <= 1'b1;
                        r_in_row   <= r_row_cnt;
                        r_in_data  <= w_word;
                        r_in_layer <= 32'(r_slot);
                        r_row_cnt  <= w_last_in ? '0 : r_row_cnt + 32'd1;
                    end else begin
                        r_lb_wr    <= 1'b1;
                        r_lb_row   <= r_row_cnt;
                        r_lb_data  <= w_word;
                        r_lb_layer <= 32'(r_slot);
                        r_row_cnt  <= r_row_cnt + 32'd1;
                    end
                end else begin
                    r_shift    <= w_word;
                    r_byte_cnt <= r_byte_cnt + BW'(1);
                end
            end else if (w_done) begin
                r_slot <= (r_slot == SW'(NUM_SLOTS - 1)) ? '0 : r_slot + SW'(1);
            end
        end
    end

`ifdef SAMPLE_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_sum  <= '0;
            r_cerr <= 1'b0;
        end else begin
            r_cerr <= w_cerr;
            if ((r_state == S_IDLE) && bus.start) r_sum <= '0;
            else if (w_accept && w_loading)       r_sum <= r_sum + bus.in_byte;
        end
    end
    assign bus.checksum_error = r_cerr;
`else
    assign bus.checksum_error = 1'b0;
`endif

    assign bus.in_ready                        = w_in_ready;
    assign bus.busy                            = (r_state != S_IDLE);
    assign bus.sample_done                     = w_done;
    assign bus.input_storage_is_write          = r_in_wr;
    assign bus.input_storage_write_row_index   = r_in_row;
    assign bus.input_storage_write_layer_index = r_in_layer;
    assign bus.input_storage_write_data        = r_in_data;
    assign bus.label_storage_is_write          = r_lb_wr;
    assign bus.label_storage_write_row_index   = r_lb_row;
    assign bus.label_storage_write_layer_index = r_lb_layer;
    assign bus.label_storage_write_data        = r_lb_data;
endmodule

// File: tb/tb_sample_loader.sv
// Directed bench for sample_loader with INPUT_ROWS=2, LABEL_ROWS=1, NUM_SLOTS=2.
module tb_sample_loader;
    logic clk_clk = 1'b0;
    logic reset_reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   cerr_n = 0;

    typedef struct {
        logic [31:0] row;
        logic [47:0] data;
        logic [31:0] layer;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [7:0]  first;
        int          gap;
        int          start_at;
        logic [47:0] e_in0;
        logic [47:0] e_in1;
        logic [47:0] e_lb0;
        logic [31:0] e_layer;
    } vec_t;

    wr_t  in_q[$];
    wr_t  lb_q[$];
    int   done_q[$];
    int   acc_q[$];
    vec_t vecs[7];

    sample_loader_if #(.DATA_WIDTH(48)) bus ();

    sample_loader #(
        .DATA_WIDTH(48), .BYTES_PER_WORD(6), .INPUT_ROWS(2), .LABEL_ROWS(1), .NUM_SLOTS(2)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .bus         (bus)
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc <= cyc + 1;

    always @(negedge clk_clk) begin
        if (bus.input_storage_is_write)
            in_q.push_back('{bus.input_storage_write_row_index, bus.input_storage_write_data,
                             bus.input_storage_write_layer_index, cyc});
        if (bus.label_storage_is_write)
            lb_q.push_back('{bus.label_storage_write_row_index, bus.label_storage_write_data,
                             bus.label_storage_write_layer_index, cyc});
        if (bus.sample_done) done_q.push_back(cyc);
        if (bus.checksum_error) cerr_n <= cerr_n + 1;
        if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic st, output int waited);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        bus.start    = st;
        @(negedge clk_clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk_clk);
            n++;
        end
        if (n >= 50) chk("byte_accept_timeout", 64'(n), 64'(0));
        tick();
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        waited = n;
        repeat (gap) tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_clk);
        while (bus.busy && n < 20) begin
            @(negedge clk_clk);
            n++;
        end
        if (n >= 20) chk("idle_timeout", 64'(n), 64'(0));
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"},   64'(bus.in_ready), 64'(0));
        chk({tag, "_busy"},       64'(bus.busy), 64'(0));
        chk({tag, "_done"},       64'(bus.sample_done), 64'(0));
        chk({tag, "_cerr"},       64'(bus.checksum_error), 64'(0));
        chk({tag, "_in_wr"},      64'(bus.input_storage_is_write), 64'(0));
        chk({tag, "_in_layer"},   64'(bus.input_storage_write_layer_index), 64'(0));
        chk({tag, "_in_row"},     64'(bus.input_storage_write_row_index), 64'(0));
        chk({tag, "_in_data"},    64'(bus.input_storage_write_data), 64'(0));
        chk({tag, "_lb_wr"},      64'(bus.label_storage_is_write), 64'(0));
        chk({tag, "_lb_layer"},   64'(bus.label_storage_write_layer_index), 64'(0));
        chk({tag, "_lb_row"},     64'(bus.label_storage_write_row_index), 64'(0));
        chk({tag, "_lb_data"},    64'(bus.label_storage_write_data), 64'(0));
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int ib, lbb, db, ab, st, w;
        logic [7:0] b;
        string t;
        t = $sformatf("v%0d", id);
        ib = in_q.size(); lbb = lb_q.size(); db = done_q.size(); ab = acc_q.size();
        st = 0;
        do_start();
        for (int i = 0; i < 18; i++) begin
            b = v.first + 8'(i);
            send_byte(b, v.gap, 1'(i == v.start_at), w);
            st += w;
        end
`ifdef SAMPLE_LOADER_CHECKSUM_EN
        b = 8'h00;
        for (int i = 0; i < 18; i++) b = b + v.first + 8'(i);
        send_byte(b, 0, 1'b0, w);
        st += w;
`endif
        wait_idle();
        chk({t, "_stall"}, 64'(st), 64'(0));
        chk({t, "_n_in"}, 64'(in_q.size() - ib), 64'(2));
        if (in_q.size() - ib == 2) begin
            chk({t, "_in0_row"},   64'(in_q[ib].row), 64'(0));
            chk({t, "_in0_data"},  64'(in_q[ib].data), 64'(v.e_in0));
            chk({t, "_in0_layer"}, 64'(in_q[ib].layer), 64'(v.e_layer));
            chk({t, "_in0_cyc"},   64'(in_q[ib].cyc), 64'(acc_q[ab+5] + 1));
            chk({t, "_in1_row"},   64'(in_q[ib+1].row), 64'(1));
            chk({t, "_in1_data"},  64'(in_q[ib+1].data), 64'(v.e_in1));
            chk({t, "_in1_layer"}, 64'(in_q[ib+1].layer), 64'(v.e_layer));
            chk({t, "_in1_cyc"},   64'(in_q[ib+1].cyc), 64'(acc_q[ab+11] + 1));
        end
        chk({t, "_n_lb"}, 64'(lb_q.size() - lbb), 64'(1));
        chk({t, "_n_done"}, 64'(done_q.size() - db), 64'(1));
        if (lb_q.size() - lbb == 1 && done_q.size() - db == 1) begin
            chk({t, "_lb_row"},   64'(lb_q[lbb].row), 64'(0));
            chk({t, "_lb_data"},  64'(lb_q[lbb].data), 64'(v.e_lb0));
            chk({t, "_lb_layer"}, 64'(lb_q[lbb].layer), 64'(v.e_layer));
            chk({t, "_lb_cyc"},   64'(lb_q[lbb].cyc), 64'(acc_q[ab+17] + 1));
`ifdef SAMPLE_LOADER_CHECKSUM_EN
            chk({t, "_done_cyc"}, 64'(done_q[db]), 64'(acc_q[ab+18] + 1));
`else
            chk({t, "_done_cyc"}, 64'(done_q[db]), 64'(lb_q[lbb].cyc + 1));
`endif
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc %0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ib, db, w, cb;
        vecs[0] = '{8'h01, 0, -1, 48'h060504030201, 48'h0C0B0A090807, 48'h1211100F0E0D, 32'd0};
        vecs[1] = '{8'h01, 1, -1, 48'h060504030201, 48'h0C0B0A090807, 48'h1211100F0E0D, 32'd1};
        vecs[2] = '{8'hF0, 0, -1, 48'hF5F4F3F2F1F0, 48'hFBFAF9F8F7F6, 48'h0100FFFEFDFC, 32'd0};
        vecs[3] = '{8'h80, 2, -1, 48'h858483828180, 48'h8B8A89888786, 48'h91908F8E8D8C, 32'd1};
        vecs[4] = '{8'h40, 0,  3, 48'h454443424140, 48'h4B4A49484746, 48'h51504F4E4D4C, 32'd0};
        vecs[5] = '{8'h01, 0, -1, 48'h060504030201, 48'h0C0B0A090807, 48'h1211100F0E0D, 32'd1};
        vecs[6] = '{8'h30, 1, -1, 48'h353433323130, 48'h3B3A39383736, 48'h41403F3E3D3C, 32'd0};

        reset_reset  = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        check_zero("rst");
        tick();
        reset_reset = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

        // Abort after 9 bytes: only the first input word lands, slot stays at 1.
        ib = in_q.size(); db = done_q.size();
        do_start();
        for (int i = 0; i < 9; i++) send_byte(8'h21 + 8'(i), 0, 1'b0, w);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk_clk);
        chk("abort9_busy", 64'(bus.busy), 64'(0));
        chk("abort9_n_in", 64'(in_q.size() - ib), 64'(1));
        if (in_q.size() - ib == 1) begin
            chk("abort9_data",  64'(in_q[ib].data), 64'h262524232221);
            chk("abort9_layer", 64'(in_q[ib].layer), 64'(1));
        end
        chk("abort9_n_done", 64'(done_q.size() - db), 64'(0));
        tick();
        run_vec(vecs[5], 5);

        // Abort on the same cycle as a word's sixth byte: that word never strobes.
        ib = in_q.size(); db = done_q.size();
        do_start();
        for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 0, 1'b0, w);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h55;
        bus.abort    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        repeat (3) tick();
        @(negedge clk_clk);
        chk("abortlast_busy", 64'(bus.busy), 64'(0));
        chk("abortlast_n_in", 64'(in_q.size() - ib), 64'(0));
        chk("abortlast_n_done", 64'(done_q.size() - db), 64'(0));
        tick();

        // Reset while loading the label word.
        do_start();
        for (int i = 0; i < 14; i++) send_byte(8'h60 + 8'(i), 0, 1'b0, w);
        reset_reset = 1'b1;
        @(posedge clk_clk);
        @(negedge clk_clk);
        check_zero("midrst");
        tick();
        reset_reset = 1'b0;
        tick();

`ifdef SAMPLE_LOADER_CHECKSUM_EN
        db = done_q.size(); cb = cerr_n;
        do_start();
        for (int i = 0; i < 18; i++) send_byte(8'h01 + 8'(i), 0, 1'b0, w);
        send_byte(8'h00, 0, 1'b0, w);
        wait_idle();
        chk("badsum_cerr", 64'(cerr_n - cb), 64'(1));
        chk("badsum_n_done", 64'(done_q.size() - db), 64'(0));
`else
        cb = cerr_n;
`endif
        run_vec(vecs[6], 6);
`ifndef SAMPLE_LOADER_CHECKSUM_EN
        chk("no_cerr", 64'(cerr_n - cb), 64'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sample_loader.md
# sample_loader

Upstream feeder for the data path's input and label storages. Accepts a byte stream of one training sample (input vector, then label vector), assembles little-endian 48-bit fixed-point words, and drives the input-storage and label-storage write interfaces with slot/row addressing. One sample per `start`; the slot index wraps so the data path can consume while the next sample loads.

## Interface
Parameters:
- `DATA_WIDTH`, 48, storage word width; must equal 8 × `BYTES_PER_WORD`
- `BYTES_PER_WORD`, 6, bytes per word
- `INPUT_ROWS`, 4, words per sample routed to input storage (≥1)
- `LABEL_ROWS`, 2, words per sample routed to label storage (≥1)
- `NUM_SLOTS`, 2, sample slots; drives layer index, wraps modulo this value (≥1)

Ports:
- `clk_clk` in 1: the single clock; all logic on rising edge
- `reset_reset` in 1: synchronous, active-high reset
- `start` in 1: begin loading a sample; honoured only in IDLE
- `abort` in 1: discard current sample, return to IDLE
- `in_valid` in 1: `in_byte` is valid
- `in_byte` in 8: stream byte
- `in_ready` out 1: byte accepted when `in_valid && in_ready`
- `input_storage_write_layer_index` out 32: current slot
- `input_storage_write_row_index` out 32: element row
- `input_storage_write_data` out 48: assembled word
- `input_storage_is_write` out 1: one-cycle write strobe
- `label_storage_write_layer_index` / `_row_index` / `_write_data` / `_is_write`: same meaning for label storage
- `busy` out 1: not IDLE
- `sample_done` out 1: one-cycle pulse, sample accepted
- `checksum_error` out 1: one-cycle pulse (see Configuration)

## Operation
- States: IDLE → LOAD_INPUT → LOAD_LABEL → [CHECK] → DONE → IDLE.
- IDLE: `in_ready`=0; `start`=1 → LOAD_INPUT, byte/row counters cleared.
- LOAD_*: `in_ready`=1; each accepted byte written into shift register at bits [8k+7:8k], k = byte count (first byte = LSBs).
- On accepting byte `BYTES_PER_WORD-1`: word complete; byte count → 0; row count increments. Last input row → LOAD_LABEL, row count → 0. Last label row → CHECK (if enabled) else DONE.
- DONE (one cycle): `sample_done`=1, slot ← (slot+1) mod `NUM_SLOTS`, → IDLE.
- Row index zero-extended to 32 bits; slot zero-extended to 32 bits; both storages share the slot value.
- `abort` (any non-IDLE state, highest priority after reset): → IDLE, partial word discarded, no strobe for the partial word, slot unchanged, no `sample_done`. Words already written stay written.
- `start` while busy: ignored.
- Reset: state IDLE, slot 0, counters 0; all outputs 0 (`in_ready`, strobes, `busy`, `sample_done`, `checksum_error`, addresses, data).

## Timing
- Throughput: one byte per cycle; `in_ready` is not deasserted mid-sample.
- Write latency: `*_is_write` high exactly one cycle, the cycle after the final byte of the word is accepted; address/data registered and stable in that cycle, hold last value otherwise.
- `sample_done` rises one cycle after the last label strobe (no checksum) or after checksum byte accept cycle+1.
- `busy` high from the cycle after `start` through the DONE cycle.
- `start` in the DONE cycle ignored; earliest restart is first IDLE cycle.
- Abort coinciding with final byte: abort wins, no strobe for that word.

## Configuration
- `SAMPLE_LOADER_CHECKSUM_EN` defined: after last label word, CHECK state accepts one extra byte; expected = sum of all data bytes mod 256. Match → DONE. Mismatch → `checksum_error` pulse one cycle, → IDLE, slot not advanced, no `sample_done`.
- Undefined: no CHECK state, no checksum logic; `checksum_error` tied 0.

## Test plan
- INPUT_ROWS=2, LABEL_ROWS=1: start, bytes 0x01..0x12 → input writes row0=0x060504030201, row1=0x0C0B0A090807, label row0=0x1211100F0E0D, all layer 0, then `sample_done`, next sample at layer 1, third at layer 0.
- Byte stream with `in_valid` gaps (every other cycle) → identical writes, strobe one cycle after each 6th byte.
- Abort after 9 bytes → one input strobe only, IDLE, slot unchanged, restart writes row 0.
- Reset asserted mid-LOAD_LABEL → all outputs 0 next cycle, slot 0.
- `start` pulsed during LOAD_INPUT → no effect on counters or writes.
- With macro: correct checksum 0xAB → `sample_done`; checksum 0x00 → `checksum_error` pulse, slot not advanced.
